// File: rtl/block_pe_param.sv
// Parametrised CGRA processing element: operand crossbar, one ALU, one scratch MEM, registered output crossbar.
// Config arrives on a bit-serial scan chain and is copied into active config on commit.

module block_pe_param_xsel #(
  parameter int DW   = 32,
  parameter int SRC  = 6,
  parameter int SELW = 3
) (
  input  logic [SRC-1:0][DW-1:0] src_i,
  input  logic [SELW-1:0]        sel_i,
  output logic [DW-1:0]          dat_o
);
  // Unused encodings above the last real source read as zero.
  assign dat_o = (int'(sel_i) < SRC) ? src_i[sel_i] : '0;
endmodule

module block_pe_param #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 2,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          config_en,
  input  logic                          config_in,
  input  logic                          config_commit,
  output logic                          config_out,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data
);
  localparam int SRC   = NUM_IN + 2;
  localparam int SELW  = $clog2(SRC);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int CFG_W = 4*SELW + 4 + 2 + NUM_OUT*SELW;
  localparam int NSEL  = 4 + NUM_OUT;

  logic [CFG_W-1:0]                    shd_q, act_q;
  logic [DATA_WIDTH-1:0]               alu_q, alu_d, mrd_q;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0]  out_q;
  logic [SRC-1:0][DATA_WIDTH-1:0]      src;
  logic [NSEL-1:0][DATA_WIDTH-1:0]     sel_dat;
  logic [DATA_WIDTH-1:0]               mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]               op_a, op_b, op_wd;
  logic [AW-1:0]                       maddr;
  logic [4:0]                          sh;
  logic [3:0]                          alu_op;
  logic [1:0]                          mem_mode;

  // Shadow shifts while active keeps running; commit copies the pre-shift shadow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shd_q <= '0;
      act_q <= '0;
    end else begin
      if (config_en)     shd_q <= {config_in, shd_q[CFG_W-1:1]};
      if (config_commit) act_q <= shd_q;
    end
  end

  assign config_out = shd_q[0];
  assign alu_op     = act_q[4*SELW +: 4];
  assign mem_mode   = act_q[4*SELW+4 +: 2];

  always_comb begin
    src = '0;
    for (int k = 0; k < NUM_IN; k++) src[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    src[NUM_IN]   = alu_q;
    src[NUM_IN+1] = mrd_q;
  end

  // Selectors 0..3 are operands; the rest are outputs, placed after alu_op/mem_mode.
  for (genvar n = 0; n < NSEL; n++) begin : g_sel
    localparam int OFS = (n < 4) ? n*SELW : n*SELW + 6;
    block_pe_param_xsel #(.DW(DATA_WIDTH), .SRC(SRC), .SELW(SELW)) u_xsel (
      .src_i (src),
      .sel_i (act_q[OFS +: SELW]),
      .dat_o (sel_dat[n])
    );
  end

  assign op_a  = sel_dat[0];
  assign op_b  = sel_dat[1];
  assign maddr = sel_dat[2][AW-1:0];
  assign op_wd = sel_dat[3];
  assign sh    = op_b[4:0];

  always_comb begin
    alu_d = '0;
    case (alu_op)
      4'd0:  alu_d = op_a + op_b;
      4'd1:  alu_d = op_a - op_b;
      4'd2:  alu_d = op_a * op_b;
      4'd3:  alu_d = op_a & op_b;
      4'd4:  alu_d = op_a | op_b;
      4'd5:  alu_d = op_a ^ op_b;
      4'd6:  alu_d = op_a << sh;
      4'd7:  alu_d = op_a >> sh;
      4'd8:  alu_d = DATA_WIDTH'($signed(op_a) >>> sh);
      4'd9:  alu_d = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      4'd10: alu_d = {{(DATA_WIDTH-1){1'b0}}, (op_a == op_b)};
      4'd11: alu_d = op_a;
      default: alu_d = '0;
    endcase
  end

  // Scratch array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_mode[1]) mem[maddr] <= op_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_q <= '0;
      mrd_q <= '0;
      out_q <= '0;
    end else begin
      alu_q <= alu_d;
      if (mem_mode[0]) mrd_q <= mem[maddr];
      for (int j = 0; j < NUM_OUT; j++) out_q[j] <= sel_dat[4+j];
    end
  end

  assign out_data = out_q;
endmodule

// File: tb/tb_block_pe_param.sv
// Self-checking bench for block_pe_param: scan chain, ALU table, MEM, accumulator, reset and live reconfig.
module tb_block_pe_param;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int NO = 2;

  logic            clk = 1'b0;
  logic            reset, config_en, config_in, config_commit;
  logic            config_out;
  logic [NI*DW-1:0] in_data;
  logic [NO*DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[17];

  block_pe_param #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .MEM_DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .config_en     (config_en),
    .config_in     (config_in),
    .config_commit (config_commit),
    .config_out    (config_out),
    .in_data       (in_data),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] mkcfg(input int o0, o1, o2, o3, alu, mode, s0, s1);
    return {3'(s1), 3'(s0), 2'(mode), 4'(alu), 3'(o3), 3'(o2), 3'(o1), 3'(o0)};
  endfunction

  function automatic logic [31:0] outj(input int j);
    return out_data[j*DW +: DW];
  endfunction

  task automatic set_in(input int k, input logic [31:0] v);
    in_data[k*DW +: DW] = v;
  endtask

  // Returns at the negedge following the commit edge.
  task automatic load_cfg(input logic [23:0] c);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); config_en = 1'b1; config_in = c[i];
    end
    @(negedge clk); config_en = 1'b0; config_in = 1'b0; config_commit = 1'b1;
    @(negedge clk); config_commit = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    logic [23:0] pat;
    logic [23:0] acc_cfg;
    logic [31:0] expv;

    tv[0]  = '{"add",     32'd7,        32'd5,        4'd0,  32'd12};
    tv[1]  = '{"sub",     32'd7,        32'd5,        4'd1,  32'd2};
    tv[2]  = '{"mul",     32'd7,        32'd5,        4'd2,  32'd35};
    tv[3]  = '{"lt",      32'd7,        32'd5,        4'd9,  32'd0};
    tv[4]  = '{"shl",     32'd7,        32'd5,        4'd6,  32'd224};
    tv[5]  = '{"and",     32'h0000F0F0, 32'h0000FF00, 4'd3,  32'h0000F000};
    tv[6]  = '{"or",      32'h0000F0F0, 32'h0000FF00, 4'd4,  32'h0000FFF0};
    tv[7]  = '{"xor",     32'h0000F0F0, 32'h0000FF00, 4'd5,  32'h00000FF0};
    tv[8]  = '{"shr",     32'h80000000, 32'd4,        4'd7,  32'h08000000};
    tv[9]  = '{"sra",     32'h80000000, 32'd4,        4'd8,  32'hF8000000};
    tv[10] = '{"eq",      32'd9,        32'd9,        4'd10, 32'd1};
    tv[11] = '{"lt_uns",  32'd3,        32'hFFFFFFFF, 4'd9,  32'd1};
    tv[12] = '{"pass",    32'h0000CAFE, 32'd1,        4'd11, 32'h0000CAFE};
    tv[13] = '{"rsvd12",  32'd7,        32'd5,        4'd12, 32'd0};
    tv[14] = '{"sub_wrap",32'd5,        32'd7,        4'd1,  32'hFFFFFFFE};
    tv[15] = '{"shl_amt5",32'd1,        32'h00000023, 4'd6,  32'd8};
    tv[16] = '{"mul_trunc",32'h00010000,32'h00010000, 4'd2,  32'd0};

    reset = 1'b1; config_en = 1'b0; config_in = 1'b0; config_commit = 1'b0;
    in_data = '0;
    set_in(0, 32'h1234);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out0", outj(0), 32'd0);
    chk("rst_out1", outj(1), 32'd0);
    chk("rst_cfgout", 32'(config_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("zero_cfg_out0", outj(0), 32'h1234);
    chk("zero_cfg_out1", outj(1), 32'h1234);

    // Scan chain: shift without commit, commit, then shift the pattern back out.
    pat = 24'hA5C3F1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); config_en = 1'b1; config_in = pat[i];
    end
    @(negedge clk); config_en = 1'b0;
    chk("scan_nocommit", 32'(dut.act_q), 32'd0);
    config_commit = 1'b1;
    @(negedge clk); config_commit = 1'b0;
    chk("scan_commit", 32'(dut.act_q), 32'(pat));
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("scan_out%0d", i), 32'(config_out), 32'(pat[i]));
      config_en = 1'b1; config_in = 1'b0;
      @(negedge clk);
    end
    config_en = 1'b0;
    chk("scan_active_hold", 32'(dut.act_q), 32'(pat));

    // ALU table: result on out0 two edges after the inputs, in0 bypass on out1.
    for (int t = 0; t < 17; t++) begin
      load_cfg(mkcfg(0, 1, 0, 0, tv[t].op, 0, 4, 0));
      set_in(0, tv[t].a); set_in(1, tv[t].b);
      sb.push_back(tv[t].exp);
      @(negedge clk);
      @(negedge clk);
      chk(tv[t].nm, outj(0), sb.pop_front());
      chk({tv[t].nm, "_byp"}, outj(1), tv[t].a);
    end

    // MEM: store, load, read-before-write, load again.
    in_data = '0;
    pulse_reset();
    set_in(2, 32'd9); set_in(3, 32'h0000DEAD);
    load_cfg(mkcfg(0, 0, 2, 3, 0, 2, 0, 5));
    load_cfg(mkcfg(0, 0, 2, 3, 0, 1, 0, 5));
    @(negedge clk);
    chk("mem_ld_lat", outj(1), 32'd0);
    @(negedge clk);
    chk("mem_ld", outj(1), 32'h0000DEAD);
    set_in(3, 32'h0000BEEF);
    load_cfg(mkcfg(0, 0, 2, 3, 0, 3, 0, 5));
    @(negedge clk);
    @(negedge clk);
    chk("mem_rbw", outj(1), 32'h0000DEAD);
    load_cfg(mkcfg(0, 0, 2, 3, 0, 1, 0, 5));
    @(negedge clk);
    chk("mem_ld2", outj(1), 32'h0000BEEF);

    // Accumulator from reset: out0 shows 0,3,6,9,12,15 after the commit edge.
    in_data = '0;
    pulse_reset();
    set_in(1, 32'd3);
    acc_cfg = mkcfg(4, 1, 0, 0, 0, 0, 4, 1);
    load_cfg(acc_cfg);
    for (int k = 1; k <= 6; k++) sb.push_back(32'(3*(k-1)));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("acc%0d", k), outj(0), sb.pop_front());
    end
    chk("acc_byp", outj(1), 32'd3);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    chk("arst_out0", outj(0), 32'd0);
    chk("arst_out1", outj(1), 32'd0);
    chk("arst_alu", dut.alu_q, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    set_in(0, 32'h11);
    @(negedge clk);
    chk("post_rst_out0", outj(0), 32'h11);
    set_in(0, 32'd0);
    load_cfg(acc_cfg);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("reacc%0d", k), outj(0), 32'(3*(k-1)));
    end

    // Live reconfig: ALU reg holds 9, out0 switches to in2 one edge after the commit edge.
    set_in(1, 32'd0);
    set_in(2, 32'h55);
    load_cfg(mkcfg(4, 1, 0, 0, 0, 0, 2, 1));
    expv = 32'd9;
    chk("reconf_hold", outj(0), expv);
    @(negedge clk);
    chk("reconf_new", outj(0), 32'h55);
    @(negedge clk);
    chk("reconf_stable", outj(0), 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
